// File: rtl/de_bounce.sv
// Push-button debouncer: a two-flop synchroniser feeds a saturating stability counter.
// The clean output follows a new level only after STABLE_CYCLES consecutive stable cycles.
module de_bounce #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic n_reset,
    input  logic button_in,
    output logic DB_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s0;
    logic             s1;
    logic             cand;
    logic [CNT_W-1:0] cnt;

    // n_reset is active-high despite its name.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            s0     <= 1'b0;
            s1     <= 1'b0;
            cand   <= 1'b0;
            cnt    <= '0;
            DB_out <= 1'b0;
        end else begin
            s0 <= button_in;
            s1 <= s0;
            // Any change of the synchronised level restarts qualification from zero.
            if (s1 != cand) begin
                cand <= s1;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end else begin
                // Counter saturates; rewriting an equal level is harmless.
                DB_out <= cand;
            end
        end
    end

endmodule

// File: tb/tb_de_bounce.sv
// Directed bench for de_bounce: a default-size instance (1000 cycles) and a small
// instance (8 cycles) for the exact qualification boundary.
module tb_de_bounce;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a, btn_a, db_a;
    logic rst_b, btn_b, db_b;

    de_bounce dut_a (
        .clk       (clk),
        .n_reset   (rst_a),
        .button_in (btn_a),
        .DB_out    (db_a)
    );

    de_bounce #(.STABLE_CYCLES(8)) dut_b (
        .clk       (clk),
        .n_reset   (rst_b),
        .button_in (btn_b),
        .DB_out    (db_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: DB_out=%b required=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle; inputs changed after this apply at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input string tag, input bit sel, input int n, input logic exp);
        for (int i = 0; i < n; i++) begin
            step();
            check_val(tag, sel ? db_b : db_a, exp);
        end
    endtask

    task automatic drive_a(input logic lvl, input int n, input logic exp, input string tag);
        btn_a = lvl;
        expect_run(tag, 1'b0, n, exp);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        btn_a = 1'b1;
        btn_b = 1'b0;

        // Reset held 10 cycles with the button high.
        expect_run("reset_hold", 1'b0, 10, 1'b0);
        check_val("reset_hold_b", db_b, 1'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        expect_run("reset_release_wait", 1'b0, 1003, 1'b0);
        expect_run("reset_release_rise", 1'b0, 1, 1'b1);

        // 200-cycle low pulse while output is high.
        drive_a(1'b0, 200, 1'b1, "short_pulse_low");
        drive_a(1'b1, 1100, 1'b1, "short_pulse_after");

        // Bouncy release.
        drive_a(1'b0, 20, 1'b1, "release_bounce");
        drive_a(1'b1, 40, 1'b1, "release_bounce");
        drive_a(1'b0, 40, 1'b1, "release_bounce");
        drive_a(1'b1, 40, 1'b1, "release_bounce");
        drive_a(1'b0, 1003, 1'b1, "release_wait");
        expect_run("release_fall", 1'b0, 1, 1'b0);
        expect_run("release_hold", 1'b0, 996, 1'b0);

        // Bouncy press.
        drive_a(1'b1, 20, 1'b0, "press_bounce");
        drive_a(1'b0, 40, 1'b0, "press_bounce");
        drive_a(1'b1, 40, 1'b0, "press_bounce");
        drive_a(1'b0, 40, 1'b0, "press_bounce");
        drive_a(1'b1, 1003, 1'b0, "press_wait");
        expect_run("press_rise", 1'b0, 1, 1'b1);
        expect_run("press_hold", 1'b0, 996, 1'b1);

        // Bring output low, then reset in the middle of a rising qualification.
        drive_a(1'b0, 1003, 1'b1, "pre_mid_wait");
        expect_run("pre_mid_fall", 1'b0, 1, 1'b0);
        expect_run("pre_mid_hold", 1'b0, 100, 1'b0);
        drive_a(1'b1, 500, 1'b0, "mid_count");
        rst_a = 1'b1;
        expect_run("mid_reset", 1'b0, 1, 1'b0);
        rst_a = 1'b0;
        expect_run("mid_release_wait", 1'b0, 1003, 1'b0);
        expect_run("mid_release_rise", 1'b0, 1, 1'b1);

        // Boundary with STABLE_CYCLES=8: 9 samples rejected, 10 samples accepted.
        check_val("bnd_idle", db_b, 1'b0);
        btn_b = 1'b1;
        expect_run("bnd_9_pulse", 1'b1, 9, 1'b0);
        btn_b = 1'b0;
        expect_run("bnd_9_after", 1'b1, 30, 1'b0);
        btn_b = 1'b1;
        expect_run("bnd_10_pulse", 1'b1, 10, 1'b0);
        btn_b = 1'b0;
        expect_run("bnd_10_edge10", 1'b1, 1, 1'b0);
        expect_run("bnd_10_edge11", 1'b1, 1, 1'b1);
        expect_run("bnd_10_high", 1'b1, 9, 1'b1);
        expect_run("bnd_10_fall", 1'b1, 1, 1'b0);
        expect_run("bnd_10_low", 1'b1, 10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
